// File: rtl/result_capture_pkg.sv
// Shared defaults and types for the result-capture block.
// Entry layout everywhere: {arg, result}, arg in the upper WIDTH bits.
package result_capture_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int LED_W     = 8;

  typedef enum logic {
    ARMED,
    DISARMED
  } arm_state_e;

endpackage

// File: rtl/result_capture_if.sv
// Call bus between the upstream sequencer / function block and the capture unit.
interface result_capture_if
  import result_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             ready;
  logic             done;
  logic [WIDTH-1:0] arg;
  logic [WIDTH-1:0] result;

  modport master (output ready, output done, output arg, output result);
  modport slave  (input  ready, input  done, input  arg, input  result);

endinterface

// File: rtl/result_capture_fifo.sv
// capture_fifo: DEPTH-entry FIFO of {arg, result} pairs with count, flags and
// a sticky overflow flag for pushes dropped while full.
module capture_fifo
  import result_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [2*WIDTH-1:0]       i_din,
  output logic [2*WIDTH-1:0]       o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  // A pop frees a slot in the same cycle, so a push while full still lands.
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !w_do_push) r_overflow <= 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/result_capture.sv
// result_capture: captures each completed function call once into a FIFO,
// pops on a synchronised push-button press and shows the head entry on LED.
module result_capture
  import result_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET,
  result_capture_if.slave        call,
  input  logic                   step_n,
  input  logic                   sel,
  output logic [LED_W-1:0]       LED,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);

  localparam int EXT_W = (WIDTH > LED_W) ? WIDTH : LED_W;

  arm_state_e r_arm;
  arm_state_e w_arm_nxt;
  logic       w_capture;

  logic r_step_meta;
  logic r_step_sync;
  logic r_step_prev;
  logic w_pop_req;

  logic [2*WIDTH-1:0] w_head;
  logic [WIDTH-1:0]   w_field;
  logic [EXT_W-1:0]   w_ext;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) r_arm <= ARMED;
    else       r_arm <= w_arm_nxt;
  end

  // Re-arm only once ready drops, so a long ready&done yields one capture.
  always_comb begin
    w_arm_nxt = r_arm;
    w_capture = 1'b0;
    case (r_arm)
      ARMED: begin
        if (call.ready && call.done) begin
          w_capture = 1'b1;
          w_arm_nxt = DISARMED;
        end
      end
      DISARMED: begin
        if (!call.ready) w_arm_nxt = ARMED;
      end
      default: w_arm_nxt = ARMED;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_step_meta <= 1'b1;
      r_step_sync <= 1'b1;
      r_step_prev <= 1'b1;
    end else begin
      r_step_meta <= step_n;
      r_step_sync <= r_step_meta;
      r_step_prev <= r_step_sync;
    end
  end

  assign w_pop_req = r_step_prev && !r_step_sync;

  capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (CLOCK_50),
    .rst        (RESET),
    .i_push     (w_capture),
    .i_pop      (w_pop_req),
    .i_din      ({call.arg, call.result}),
    .o_dout     (w_head),
    .o_count    (count),
    .o_empty    (empty),
    .o_full     (full),
    .o_overflow (overflow)
  );

  assign w_field = sel ? w_head[2*WIDTH-1:WIDTH] : w_head[WIDTH-1:0];
  assign w_ext   = EXT_W'(w_field);
  assign LED     = empty ? '0 : w_ext[LED_W-1:0];

endmodule

// File: tb/tb_result_capture.sv
// Randomised and directed bench for result_capture against a queue-based model.
module tb_result_capture;

  localparam int W = 8;
  localparam int D = 8;

  logic       clk;
  logic       rst;
  logic       step_n;
  logic       sel;
  logic [7:0] led;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  result_capture_if #(.WIDTH(W)) bus ();

  result_capture #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .call     (bus),
    .step_n   (step_n),
    .sel      (sel),
    .LED      (led),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: queued {arg, result} pairs, sticky overflow,
  // "this ready period already captured" flag, and pin history of step_n.
  logic [15:0] mq[$];
  logic        m_ovf;
  logic        m_captured;
  logic        h1, h2, h3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic rdy, input logic dn, input logic [7:0] a,
                            input logic [7:0] r, input logic sn, input logic rs);
    logic pop, push, pop_ok;
    if (rs) begin
      mq.delete();
      m_ovf = 1'b0;
      m_captured = 1'b0;
      h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
    end else begin
      // Button press takes effect on the third edge after the pin falls.
      pop    = h3 && !h2;
      push   = rdy && dn && !m_captured;
      if (rdy && dn) m_captured = 1'b1;
      else if (!rdy) m_captured = 1'b0;
      pop_ok = pop && (mq.size() > 0);
      if (push && !(mq.size() < D || pop_ok)) m_ovf = 1'b1;
      if (pop_ok) void'(mq.pop_front());
      if (push && (mq.size() < D)) mq.push_back({a, r});
      h3 = h2; h2 = h1; h1 = sn;
    end
  endtask

  task automatic check_all();
    logic [15:0] head;
    head = (mq.size() > 0) ? mq[0] : 16'h0000;
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == D));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    sel = 1'b0; #1;
    chk("led_result", 32'(led), 32'(head[7:0]));
    sel = 1'b1; #1;
    chk("led_arg", 32'(led), 32'(head[15:8]));
    sel = 1'b0;
  endtask

  task automatic step(input logic rdy, input logic dn, input logic [7:0] a,
                      input logic [7:0] r, input logic sn, input logic rs);
    bus.ready = rdy; bus.done = dn; bus.arg = a; bus.result = r;
    step_n = sn; rst = rs;
    @(posedge clk);
    model_edge(rdy, dn, a, r, sn, rs);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic call_once(input logic [7:0] a, input logic [7:0] r, input int hold);
    for (int i = 0; i < hold; i++) step(1'b1, 1'b1, a, r, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic press();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(3);
  endtask

  // Pop lands on the third edge, which is also the call's detection edge.
  task automatic press_with_call(input logic [7:0] a, input logic [7:0] r);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, a, r, 1'b0, 1'b0);
    idle(3);
  endtask

  task automatic chk_led(input string tag, input logic s, input logic [7:0] exp);
    sel = s; #1;
    chk(tag, 32'(led), 32'(exp));
    sel = 1'b0;
  endtask

  logic [7:0] res_tab [4];
  logic rr, dd, sn_r, rs_r;

  initial begin
    res_tab[0] = 8'd0; res_tab[1] = 8'd1; res_tab[2] = 8'd1; res_tab[3] = 8'd2;
    bus.ready = 1'b0; bus.done = 1'b0; bus.arg = '0; bus.result = '0;
    step_n = 1'b1; sel = 1'b0; rst = 1'b1;
    mq.delete(); m_ovf = 1'b0; m_captured = 1'b0; h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;

    do_reset();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_led", 32'(led), 32'd0);
    idle(1);

    // Four calls, each with ready held 4 cycles.
    for (int i = 0; i < 4; i++) call_once(8'(i), res_tab[i], 4);
    chk("seq_count4", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk_led("seq_head_result", 1'b0, res_tab[i]);
      chk_led("seq_head_arg", 1'b1, 8'(i));
      press();
    end
    chk("seq_drained", 32'(empty), 32'd1);

    do_reset();
    call_once(8'h07, 8'h09, 10);
    chk("long_hold_count1", 32'(count), 32'd1);

    do_reset();
    for (int i = 0; i < 9; i++) call_once(8'(16 + i), 8'(32 + i), 1);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count8", 32'(count), 32'd8);
    chk_led("ovf_head", 1'b0, 8'd32);

    do_reset();
    for (int i = 0; i < 8; i++) call_once(8'(i + 1), 8'(i + 100), 1);
    press_with_call(8'hAA, 8'h55);
    chk("full_swap_count", 32'(count), 32'd8);
    chk("full_swap_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) press();
    chk_led("full_swap_tail_arg", 1'b1, 8'hAA);
    chk_led("full_swap_tail_res", 1'b0, 8'h55);
    press();

    do_reset();
    press();
    chk("empty_pop_count", 32'(count), 32'd0);
    chk("empty_pop_led", 32'(led), 32'd0);
    press_with_call(8'h03, 8'h04);
    chk("empty_pushpop_count", 32'(count), 32'd1);

    do_reset();
    for (int i = 0; i < 9; i++) call_once(8'(i), 8'(i ^ 8'h5A), 1);
    for (int i = 0; i < 3; i++) press();
    chk("pre_reset_count5", 32'(count), 32'd5);
    chk("pre_reset_ovf", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("mid_reset_count", 32'(count), 32'd0);
    chk("mid_reset_empty", 32'(empty), 32'd1);
    chk("mid_reset_ovf", 32'(overflow), 32'd0);
    chk("mid_reset_led", 32'(led), 32'd0);

    sn_r = 1'b1;
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 3) != 0);
      dd = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 3) == 0) sn_r = ~sn_r;
      rs_r = ($urandom_range(0, 149) == 0);
      step(rr, dd, 8'($urandom), 8'($urandom), sn_r, rs_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_capture.md
RESULT_CAPTURE -- requirements
Module: result_capture

Interface
REQ-001 Parameter: WIDTH, 8, bit width of the function argument and result.
REQ-002 Parameter: DEPTH, 8, number of capture FIFO entries; power of two, 2..64.
REQ-003 Port: CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: RESET  input  1  synchronous, active-high reset.
REQ-005 Port: ready  input  1  call-request strobe from the upstream sequencer, also wired to the function block.
REQ-006 Port: done  input  1  completion flag from the function block.
REQ-007 Port: arg  input  WIDTH  argument currently presented to the function block.
REQ-008 Port: result  input  WIDTH  function block result; valid while ready & done.
REQ-009 Port: step_n  input  1  active-low push-button, asynchronous to CLOCK_50; requests a pop.
REQ-010 Port: sel  input  1  display select: 0 = head result, 1 = head argument; level, not synchronised.
REQ-011 Port: LED  output  8  display of the head entry, zero-extended or truncated to 8 bits.
REQ-012 Port: count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-013 Port: empty, full  output  1 each  FIFO status flags (count==0, count==DEPTH).
REQ-014 Port: overflow  output  1  sticky flag: a completed call was dropped because the FIFO was full.

Function
REQ-015 A completed call SHALL be detected on the first CLOCK_50 cycle with ready=1 and done=1.
REQ-016 An armed flag SHALL be cleared on detection and set again only on a cycle with ready=0, so that each call is captured exactly once, however long ready & done stays high.
REQ-017 On detection, the pair {arg, result} sampled in that cycle SHALL be pushed; it becomes visible one cycle later (count, empty, LED update together).
REQ-018 A push while full with no pop in the same cycle SHALL be dropped; overflow SHALL be set; FIFO contents SHALL be unchanged.
REQ-019 step_n SHALL pass through a 2-flop synchroniser; a pop request is one cycle on the synchronised 1->0 transition (latency 3 cycles from the pin); no debounce is applied.
REQ-020 A pop request while empty SHALL be ignored, with no state change.
REQ-021 A simultaneous push and pop while full SHALL both be performed; count stays DEPTH; overflow is not set.
REQ-022 A simultaneous push and pop while empty: the push SHALL be performed and the pop ignored; count becomes 1.
REQ-023 A simultaneous push and pop otherwise: both performed; count unchanged.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-025 LED SHALL equal the head result (sel=0) or head argument (sel=1) combinationally from registered FIFO state, and 8'h00 when empty.

Reset
REQ-026 While RESET=1 at a clock edge: pointers=0, count=0, empty=1, full=0, overflow=0, armed=1, synchroniser flops=1, LED=8'h00.
REQ-027 A call completing during the reset cycle SHALL NOT be captured; FIFO storage contents need not be reset.
REQ-028 Reset asserted mid-operation SHALL discard all entries and clear overflow within that cycle.

Structure
REQ-029 A shared package SHALL hold the default WIDTH and DEPTH and the entry layout (arg in the upper WIDTH bits, result in the lower WIDTH bits).
REQ-030 The FIFO storage, pointers, count and flags SHALL be one sub-module, capture_fifo; detection, synchroniser and display logic live in result_capture.

Verification
REQ-031 Calls with arg 0..3, results 0,1,1,2, ready held 4 cycles after done -> count=4; pops yield LED 0,1,1,2 with sel=0; sel=1 gives 0,1,2,3.
REQ-032 ready & done held 10 cycles for one call -> exactly one entry (count=1).
REQ-033 Nine calls with DEPTH=8 -> full=1, overflow=1, count=8; head is the first call's result; the ninth call is absent.
REQ-034 While full, push and pop coincide -> count stays 8, overflow stays 0, new pair appears at the tail.
REQ-035 Pop while empty -> count=0, LED=8'h00; then push and pop in the same cycle -> count=1.
REQ-036 RESET pulsed with count=5 and overflow=1 -> next cycle count=0, empty=1, overflow=0, LED=8'h00.
